ibex_obi_mem_arbiter: RTL and testbench
=======================================

Name: ibex_obi_mem_arbiter

Overview:
Sits between the Ibex core's instruction and data OBI ports and the single-port on-chip RAM (ram_1p-style interface). It arbitrates both masters onto one RAM port and decodes addresses into RAM, a memory-mapped LED register, and an error region. It tracks the single outstanding transaction and routes rvalid/rdata/err back to the owning port. Replaces the ad-hoc combinational arbiter in the Cyclone10LP top level.

Parameters:
MEM_SIZE, 65536, RAM size in bytes; power of two
MEM_START, 32'h00000000, RAM base address; aligned to MEM_SIZE
LED_ADDR, 32'h00020000, word address of the LED register
LED_RESET, 4'h0, reset value of led_o

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
instr_req_i  in  1  instruction request
instr_gnt_o  out  1  instruction grant
instr_addr_i  in  32  instruction address
instr_rvalid_o  out  1  instruction response valid
instr_rdata_o  out  32  instruction read data
instr_err_o  out  1  instruction error; valid with instr_rvalid_o
data_req_i  in  1  data request
data_gnt_o  out  1  data grant
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  data write data
data_rvalid_o  out  1  data response valid
data_rdata_o  out  32  data read data
data_err_o  out  1  data error; valid with data_rvalid_o
mem_req_o  out  1  RAM request
mem_we_o  out  1  RAM write enable
mem_be_o  out  4  RAM byte enables
mem_addr_o  out  32  RAM address
mem_wdata_o  out  32  RAM write data
mem_rvalid_i  in  1  RAM response valid; latency >= 1 cycle
mem_rdata_i  in  32  RAM read data
led_o  out  4  LED register

Behaviour:
- Reset (rst_i high, asynchronous): all gnt/rvalid/err outputs 0, rdata outputs 0, mem_* outputs 0, led_o = LED_RESET, outstanding tracker cleared. A response pending at reset is dropped. No rvalid is issued for it after reset is released.
- Tracker registers: outst (1b), owner (INSTR/DATA), kind (RAM/LED/ERR), led_rdata (4b).
- Completion this cycle (done): outst && (kind != RAM || mem_rvalid_i).
- can_grant = !outst || done. Back-to-back grants are allowed in the completion cycle.
- Arbitration (default): when can_grant, data_req_i wins over instr_req_i. The winner's gnt_o is asserted combinationally in the same cycle. The loser sees gnt_o = 0 and must hold its request stable.
- Decode of the winning address:
  - RAM when (addr & ~(MEM_SIZE-1)) == MEM_START.
  - LED when addr[31:2] == LED_ADDR[31:2] and the winner is the data port.
  - ERR otherwise, including an instruction fetch to LED_ADDR.
- mem_req_o = grant && kind RAM. When mem_req_o is asserted, mem_we/be/addr/wdata carry the winner's fields (instruction port: we=0, be=4'hF). Otherwise mem_* are 0.
- On grant: outst <= 1; owner and kind are latched. If done and there is no new grant: outst <= 0.
- LED write: on grant of a data write to LED with data_be_i[0] = 1, led_o <= data_wdata_i[3:0] at the next edge.
- LED read: on grant, led_rdata is captured, so rdata reflects the pre-write value for a simultaneous read.
- Response (in the cycle done is high): owner's rvalid_o = 1.
  - RAM: rdata = mem_rdata_i, err = 0.
  - LED: rdata = {28'b0, led_rdata}, err = 0.
  - ERR: rdata = 0, err = 1.
  - Writes also get rvalid; their rdata is don't-care and is driven as 0.
- Outside the response cycle, rvalid/err = 0 and rdata = 0 for both ports. The non-owner port is always 0.
- Ordering: at most one transaction is outstanding, so responses return in grant order.
- mem_rvalid_i asserted while !outst or kind != RAM is ignored.

Optional Feature:
- Macro: IBEX_OBI_MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last-granted pointer (reset = INSTR, so data wins the first contention) updates on every grant. On contention, the port other than the last-granted one wins.
- Undefined: fixed priority, data over instruction, with no pointer register.

Test Plan:
- Reset: hold rst_i high with both reqs high -> no gnt/rvalid, mem_req_o = 0, led_o = LED_RESET; release -> normal operation with no stale rvalid.
- Instr read 0x80 alone; RAM returns mem_rvalid_i one cycle later with rdata 0x00000013 -> instr_gnt_o and mem_req_o with mem_addr_o = 0x80 in cycle 0; cycle 1 instr_rvalid_o = 1, rdata = 0x13, err = 0; data_rvalid_o = 0.
- Contention, instr read 0x100 and data read 0x200 in the same cycle, 1-cycle RAM:
  - Default -> data_gnt_o in cycle 0, instr_gnt_o in cycle 1, data_rvalid_o in cycle 1, instr_rvalid_o in cycle 2.
  - With the RR macro and repeated contention -> grants alternate data, instr, data, instr.
- Data write to LED_ADDR with wdata 0xA, be 4'b0001 -> no mem_req_o; led_o = 4'hA next cycle; data_rvalid_o with err = 0. Read of LED_ADDR -> data_rdata_o = 0x0000000A.
- Errors:
  - Data read 0x10000000 -> gnt, no mem_req_o, next cycle data_rvalid_o = 1, data_err_o = 1, rdata = 0.
  - Instr fetch to LED_ADDR -> instr_err_o = 1.
- RAM latency 3, with a second request held -> no gnt until the cycle mem_rvalid_i is asserted, then a grant in that same cycle. Asserting rst_i while outstanding -> no rvalid after release.

Source files
------------

// File: rtl/ibex_obi_mem_arbiter_if.sv
// rtl/ibex_obi_mem_arbiter_if.sv - instruction/data OBI, RAM and LED signal bundle for the memory arbiter
interface ibex_obi_mem_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [3:0]  led_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rvalid_i, mem_rdata_i,
    output led_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rvalid_i, mem_rdata_i,
    input  led_o
  );
endinterface

// File: rtl/ibex_obi_mem_arbiter.sv
// rtl/ibex_obi_mem_arbiter.sv - arbitrates Ibex instr/data OBI onto one RAM port with LED register and error decode
// IBEX_OBI_MEM_ARB_RR_EN selects round-robin arbitration instead of fixed data-over-instruction priority.
module ibex_obi_mem_arbiter #(
  parameter int unsigned MEM_SIZE  = 65536,
  parameter logic [31:0] MEM_START = 32'h0000_0000,
  parameter logic [31:0] LED_ADDR  = 32'h0002_0000,
  parameter logic [3:0]  LED_RESET = 4'h0
) (
  input logic                   clk_i,
  input logic                   rst_i,
  ibex_obi_mem_arbiter_if.slave bus
);

  typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;
  typedef enum logic [1:0] {KIND_RAM, KIND_LED, KIND_ERR} kind_e;

  localparam logic [31:0] MEM_MASK = ~(MEM_SIZE - 32'd1);

  logic        outst_q;
  owner_e      owner_q;
  kind_e       kind_q;
  logic        wr_q;
  logic [3:0]  led_rdata_q;
  logic [3:0]  led_q;

  logic        done;
  logic        can_grant;
  logic        sel_data;
  logic        grant;
  logic [31:0] win_addr;
  kind_e       win_kind;
  logic [31:0] resp_rdata;

  assign done      = outst_q && (kind_q != KIND_RAM || bus.mem_rvalid_i);
  assign can_grant = !rst_i && (!outst_q || done);

`ifdef IBEX_OBI_MEM_ARB_RR_EN
  owner_e last_q;
  assign sel_data = bus.data_req_i && (!bus.instr_req_i || last_q == OWN_INSTR);
`else
  assign sel_data = bus.data_req_i;
`endif

  assign grant    = can_grant && (bus.data_req_i || bus.instr_req_i);
  assign win_addr = sel_data ? bus.data_addr_i : bus.instr_addr_i;

  // LED is only reachable from the data port; instruction fetches there fault.
  always_comb begin
    win_kind = KIND_ERR;
    if ((win_addr & MEM_MASK) == MEM_START) begin
      win_kind = KIND_RAM;
    end else if (sel_data && win_addr[31:2] == LED_ADDR[31:2]) begin
      win_kind = KIND_LED;
    end
  end

  assign bus.data_gnt_o  = grant && sel_data;
  assign bus.instr_gnt_o = grant && !sel_data;

  assign bus.mem_req_o   = grant && win_kind == KIND_RAM;
  assign bus.mem_we_o    = bus.mem_req_o && sel_data && bus.data_we_i;
  assign bus.mem_be_o    = !bus.mem_req_o ? 4'h0 : (sel_data ? bus.data_be_i : 4'hF);
  assign bus.mem_addr_o  = bus.mem_req_o ? win_addr : 32'h0;
  assign bus.mem_wdata_o = (bus.mem_req_o && sel_data) ? bus.data_wdata_i : 32'h0;
  assign bus.led_o       = led_q;

  always_comb begin
    resp_rdata = 32'h0;
    if (!wr_q) begin
      case (kind_q)
        KIND_RAM: resp_rdata = bus.mem_rdata_i;
        KIND_LED: resp_rdata = {28'h0, led_rdata_q};
        default:  resp_rdata = 32'h0;
      endcase
    end
  end

  assign bus.instr_rvalid_o = done && owner_q == OWN_INSTR;
  assign bus.instr_rdata_o  = bus.instr_rvalid_o ? resp_rdata : 32'h0;
  assign bus.instr_err_o    = bus.instr_rvalid_o && kind_q == KIND_ERR;
  assign bus.data_rvalid_o  = done && owner_q == OWN_DATA;
  assign bus.data_rdata_o   = bus.data_rvalid_o ? resp_rdata : 32'h0;
  assign bus.data_err_o     = bus.data_rvalid_o && kind_q == KIND_ERR;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q     <= 1'b0;
      owner_q     <= OWN_INSTR;
      kind_q      <= KIND_RAM;
      wr_q        <= 1'b0;
      led_rdata_q <= 4'h0;
      led_q       <= LED_RESET;
    end else begin
      if (grant) begin
        outst_q     <= 1'b1;
        owner_q     <= sel_data ? OWN_DATA : OWN_INSTR;
        kind_q      <= win_kind;
        wr_q        <= sel_data && bus.data_we_i;
        led_rdata_q <= led_q;
      end else if (done) begin
        outst_q <= 1'b0;
      end
      if (grant && sel_data && win_kind == KIND_LED && bus.data_we_i && bus.data_be_i[0]) begin
        led_q <= bus.data_wdata_i[3:0];
      end
    end
  end

`ifdef IBEX_OBI_MEM_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OWN_INSTR;
    end else if (grant) begin
      last_q <= sel_data ? OWN_DATA : OWN_INSTR;
    end
  end
`endif

endmodule

// File: tb/tb_ibex_obi_mem_arbiter.sv
// tb/tb_ibex_obi_mem_arbiter.sv - scoreboard bench for the OBI memory arbiter
module tb_ibex_obi_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ibex_obi_mem_arbiter_if bus ();
  ibex_obi_mem_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic port, input logic [31:0] rdata, input logic err);
    sb.push_back({port, rdata, err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string name, input logic ig, input logic dg);
    @(negedge clk);
    chk({name, "_instr_gnt"}, 32'(bus.instr_gnt_o), 32'(ig));
    chk({name, "_data_gnt"}, 32'(bus.data_gnt_o), 32'(dg));
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.instr_rvalid_o && bus.data_rvalid_o) begin
      checks++;
      errors++;
      $display("FAIL both_rvalid actual=11 expected=one port only");
    end else if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid instr=%0b data=%0b expected none", bus.instr_rvalid_o, bus.data_rvalid_o);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_port", 32'(bus.data_rvalid_o), 32'(mon_e.port));
        if (bus.data_rvalid_o) begin
          chk("data_rdata", bus.data_rdata_o, mon_e.rdata);
          chk("data_err", 32'(bus.data_err_o), 32'(mon_e.err));
          chk("instr_idle_rdata", bus.instr_rdata_o, 32'h0);
        end else begin
          chk("instr_rdata", bus.instr_rdata_o, mon_e.rdata);
          chk("instr_err", 32'(bus.instr_err_o), 32'(mon_e.err));
          chk("data_idle_rdata", bus.data_rdata_o, 32'h0);
        end
      end
    end else begin
      chk("idle_rdata", bus.instr_rdata_o | bus.data_rdata_o, 32'h0);
      chk("idle_err", 32'({bus.instr_err_o, bus.data_err_o}), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic win;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h100;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'hF;
    bus.data_addr_i  = 32'h200;
    bus.data_wdata_i = 32'h0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;

    // Reset with both requests high
    repeat (2) @(negedge clk);
    chk("rst_instr_gnt", 32'(bus.instr_gnt_o), 32'h0);
    chk("rst_data_gnt", 32'(bus.data_gnt_o), 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_led", 32'(bus.led_o), 32'h0);
    step();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b0;
    rst = 1'b0;
    chk_gnt("post_rst", 1'b0, 1'b0);

    // Lone instruction fetch from RAM
    step();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h80;
    expect_rsp(1'b0, 32'h13, 1'b0);
    chk_gnt("ifetch", 1'b1, 1'b0);
    chk("ifetch_mem_req", 32'(bus.mem_req_o), 32'h1);
    chk("ifetch_mem_addr", bus.mem_addr_o, 32'h80);
    chk("ifetch_mem_be", 32'(bus.mem_be_o), 32'hF);
    chk("ifetch_mem_we", 32'(bus.mem_we_o), 32'h0);
    step();
    bus.instr_req_i  = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h13;
    step();
    bus.mem_rvalid_i = 1'b0;

    // Contention: data first, instruction granted in the completion cycle
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h100;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 32'h200;
    expect_rsp(1'b1, 32'h2222, 1'b0);
    expect_rsp(1'b0, 32'h1111, 1'b0);
    chk_gnt("cont0", 1'b0, 1'b1);
    chk("cont0_mem_addr", bus.mem_addr_o, 32'h200);
    step();
    bus.data_req_i   = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h2222;
    chk_gnt("cont1", 1'b1, 1'b0);
    chk("cont1_mem_addr", bus.mem_addr_o, 32'h100);
    step();
    bus.instr_req_i = 1'b0;
    bus.mem_rdata_i = 32'h1111;
    chk_gnt("cont2", 1'b0, 1'b0);
    step();
    bus.mem_rvalid_i = 1'b0;

    // Sustained contention: four back-to-back grants
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef IBEX_OBI_MEM_ARB_RR_EN
      win = (k % 2 == 0);
`else
      win = 1'b1;
`endif
      expect_rsp(win, 32'hA000 + 32'(k), 1'b0);
      if (k > 0) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hA000 + 32'(k - 1);
      end
      chk_gnt($sformatf("sustain%0d", k), !win, win);
      step();
    end
    bus.instr_req_i  = 1'b0;
    bus.data_req_i   = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hA003;
    chk_gnt("sustain_end", 1'b0, 1'b0);
    step();
    bus.mem_rvalid_i = 1'b0;

    // RAM write: fields forwarded, response rdata forced to zero
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'hC;
    bus.data_addr_i  = 32'h40;
    bus.data_wdata_i = 32'h1234_5678;
    expect_rsp(1'b1, 32'h0, 1'b0);
    chk_gnt("ramwr", 1'b0, 1'b1);
    chk("ramwr_mem_we", 32'(bus.mem_we_o), 32'h1);
    chk("ramwr_mem_be", 32'(bus.mem_be_o), 32'hC);
    chk("ramwr_mem_wdata", bus.mem_wdata_o, 32'h1234_5678);
    step();
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hFFFF_FFFF;
    step();
    bus.mem_rvalid_i = 1'b0;

    // LED write, masked LED write, LED read
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'b0001;
    bus.data_addr_i  = 32'h0002_0000;
    bus.data_wdata_i = 32'hA;
    expect_rsp(1'b1, 32'h0, 1'b0);
    chk_gnt("ledwr", 1'b0, 1'b1);
    chk("ledwr_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("ledwr_led_before", 32'(bus.led_o), 32'h0);
    step();
    bus.data_req_i = 1'b0;
    @(negedge clk);
    chk("ledwr_led_after", 32'(bus.led_o), 32'hA);
    step();
    bus.data_req_i   = 1'b1;
    bus.data_be_i    = 4'b0010;
    bus.data_wdata_i = 32'h5;
    expect_rsp(1'b1, 32'h0, 1'b0);
    chk_gnt("ledwr_nobe0", 1'b0, 1'b1);
    step();
    bus.data_req_i = 1'b0;
    bus.data_we_i  = 1'b0;
    @(negedge clk);
    chk("ledwr_nobe0_led", 32'(bus.led_o), 32'hA);
    step();
    bus.data_req_i = 1'b1;
    bus.data_be_i  = 4'hF;
    expect_rsp(1'b1, 32'hA, 1'b0);
    chk_gnt("ledrd", 1'b0, 1'b1);
    chk("ledrd_mem_req", 32'(bus.mem_req_o), 32'h0);
    step();
    bus.data_req_i = 1'b0;

    // Error region and RAM upper boundary
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h1000_0000;
    expect_rsp(1'b1, 32'h0, 1'b1);
    chk_gnt("derr", 1'b0, 1'b1);
    chk("derr_mem_req", 32'(bus.mem_req_o), 32'h0);
    step();
    bus.data_req_i   = 1'b0;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0002_0000;
    expect_rsp(1'b0, 32'h0, 1'b1);
    chk_gnt("ierr_led", 1'b1, 1'b0);
    chk("ierr_mem_req", 32'(bus.mem_req_o), 32'h0);
    step();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h0000_FFFC;
    expect_rsp(1'b1, 32'hBEEF, 1'b0);
    chk_gnt("ram_top", 1'b0, 1'b1);
    chk("ram_top_mem_req", 32'(bus.mem_req_o), 32'h1);
    chk("ram_top_mem_addr", bus.mem_addr_o, 32'h0000_FFFC);
    step();
    bus.data_req_i   = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBEEF;
    step();
    bus.mem_rvalid_i = 1'b0;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 32'h0001_0000;
    expect_rsp(1'b1, 32'h0, 1'b1);
    chk_gnt("ram_past", 1'b0, 1'b1);
    chk("ram_past_mem_req", 32'(bus.mem_req_o), 32'h0);
    step();
    bus.data_req_i = 1'b0;
    step();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD;
    step();
    bus.mem_rvalid_i = 1'b0;

    // RAM latency 3 with a data request held behind it
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h300;
    expect_rsp(1'b0, 32'h33, 1'b0);
    chk_gnt("lat_c0", 1'b1, 1'b0);
    step();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h400;
    expect_rsp(1'b1, 32'h44, 1'b0);
    chk_gnt("lat_c1", 1'b0, 1'b0);
    step();
    chk_gnt("lat_c2", 1'b0, 1'b0);
    step();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h33;
    chk_gnt("lat_c3", 1'b0, 1'b1);
    chk("lat_c3_mem_addr", bus.mem_addr_o, 32'h400);
    step();
    bus.data_req_i  = 1'b0;
    bus.mem_rdata_i = 32'h44;
    step();
    bus.mem_rvalid_i = 1'b0;

    // Reset while a RAM read is outstanding: its late response is dropped
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h500;
    chk_gnt("rst_out", 1'b0, 1'b1);
    step();
    bus.data_req_i = 1'b0;
    rst = 1'b1;
    chk_gnt("rst_out_hold", 1'b0, 1'b0);
    chk("rst_out_led", 32'(bus.led_o), 32'h0);
    step();
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h55;
    chk_gnt("rst_out_rel", 1'b0, 1'b0);
    step();
    bus.mem_rvalid_i = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
